logistic_orbit_scheduler: RTL and testbench

- Time-multiplexes one shared logistic-function unit (multi-cycle, level start/done handshake) across NCH independent orbit channels.
- Each channel holds its own state x_i. The scheduler iterates every channel `times` times in round-robin order, then publishes a stable snapshot of all results for the display path.
- Sits between the parameter/control logic (mu, times, run) and the single evaluation unit. It replaces one evaluation unit per channel.

---
 rtl/logistic_pkg.sv | 24 ++
 rtl/orbit_state_bank.sv | 61 ++++++
 rtl/logistic_orbit_scheduler.sv | 179 +++++++++++++++++
 tb/tb_logistic_orbit_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logistic_pkg.sv
// Shared constants and FSM state type for the time-multiplexed logistic orbit scheduler.
package logistic_pkg;

    localparam int unsigned NCH       = 7;
    localparam int unsigned W         = 17;
    localparam int unsigned MUW       = 18;
    localparam int unsigned CNTW      = 9;
    localparam int unsigned FRAC      = 16;
    localparam logic [W-1:0] ONE      = 17'h10000;
    // Channel i is seeded at base + i*SEED_STEP (mod 2^W).
    localparam int unsigned SEED_STEP = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_CLR,
        S_ADVANCE,
        S_DONE,
        S_ABORT
    } state_e;

endpackage

// File: rtl/orbit_state_bank.sv
// Per-channel orbit state registers with seed load, indexed write/read and a tear-free snapshot.
module orbit_state_bank
    import logistic_pkg::*;
#(
    parameter int unsigned BANK_NCH = 7,
    parameter int unsigned BANK_W   = 17,
    parameter int unsigned IW       = $clog2(BANK_NCH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic [BANK_W-1:0]        seed_base_i,
    input  logic                     wr_en_i,
    input  logic [IW-1:0]            idx_i,
    input  logic [BANK_W-1:0]        wr_data_i,
    output logic [BANK_W-1:0]        rd_data_o,
    input  logic                     snap_x_i,
    input  logic                     snap_seed_i,
    output logic [BANK_NCH*BANK_W-1:0] snap_o
);

    logic [BANK_W-1:0]          x_q [BANK_NCH];
    logic [BANK_NCH*BANK_W-1:0] snap_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BANK_NCH; i++) begin
                x_q[i] <= '0;
            end
            snap_q <= '0;
        end else begin
            for (int unsigned i = 0; i < BANK_NCH; i++) begin
                if (load_i) begin
                    x_q[i] <= seed_base_i + BANK_W'(i * SEED_STEP);
                end else if (wr_en_i && (idx_i == IW'(i))) begin
                    x_q[i] <= wr_data_i;
                end
            end
            // Seed snapshot is needed when x_q is being loaded in the same cycle.
            for (int unsigned i = 0; i < BANK_NCH; i++) begin
                if (snap_seed_i) begin
                    snap_q[i*BANK_W +: BANK_W] <= seed_base_i + BANK_W'(i * SEED_STEP);
                end else if (snap_x_i) begin
                    snap_q[i*BANK_W +: BANK_W] <= x_q[i];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned i = 0; i < BANK_NCH; i++) begin
            if (idx_i == IW'(i)) begin
                rd_data_o = x_q[i];
            end
        end
    end

    assign snap_o = snap_q;

endmodule

// File: rtl/logistic_orbit_scheduler.sv
// Round-robin scheduler sharing one multi-cycle logistic unit across NCH orbit channels,
// publishing a snapshot of all channel states when a sweep completes.
module logistic_orbit_scheduler
    import logistic_pkg::*;
#(
    parameter int unsigned NCH  = 7,
    parameter int unsigned W    = 17,
    parameter int unsigned MUW  = 18,
    parameter int unsigned CNTW = 9
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       run,
    input  logic [MUW-1:0]             mu,
    input  logic [CNTW-1:0]            times,
    input  logic [W-1:0]               dzero_base,
    output logic                       fu_start,
    output logic [W-1:0]               fu_x,
    output logic [MUW-1:0]             fu_mu,
    input  logic [W-1:0]               fu_y,
    input  logic                       fu_done,
    output logic                       busy,
    output logic                       all_done,
    output logic [CNTW-1:0]            iter_count,
    output logic [$clog2(NCH)-1:0]     cur_ch,
    output logic [NCH*W-1:0]           results
);

    localparam int unsigned CHW = $clog2(NCH);

    state_e          state_q;
    logic            run_q;
    logic [MUW-1:0]  mu_l_q;
    logic [CNTW-1:0] times_l_q;
    logic            start_q;
    logic [W-1:0]    fx_q;
    logic [MUW-1:0]  fmu_q;
    logic            busy_q;
    logic            done_q;
    logic [CNTW-1:0] iter_q;
    logic [CHW-1:0]  ch_q;

    logic            run_edge;
    logic            abortable;
    logic            last_ch;
    logic [CNTW-1:0] iter_next;
    logic            bank_load;
    logic            bank_wr;
    logic            snap_x;
    logic            snap_seed;
    logic [W-1:0]    bank_rd;

    assign run_edge  = run & ~run_q;
    assign abortable = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE) ||
                       (state_q == S_WAIT_CLR) || (state_q == S_ADVANCE);
    assign last_ch   = (ch_q == CHW'(NCH - 1));
    assign iter_next = iter_q + CNTW'(1);

    // Bank strobes mirror the FSM transitions below; abort takes priority so they gate on run.
    assign bank_load = (state_q == S_LOAD);
    assign snap_seed = (state_q == S_LOAD) && (times == '0);
    assign bank_wr   = (state_q == S_WAIT_DONE) && fu_done && run;
    assign snap_x    = (state_q == S_ADVANCE) && run && last_ch && (iter_next == times_l_q);

    orbit_state_bank #(
        .BANK_NCH (NCH),
        .BANK_W   (W),
        .IW       (CHW)
    ) u_bank (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .load_i      (bank_load),
        .seed_base_i (dzero_base),
        .wr_en_i     (bank_wr),
        .idx_i       (ch_q),
        .wr_data_i   (fu_y),
        .rd_data_o   (bank_rd),
        .snap_x_i    (snap_x),
        .snap_seed_i (snap_seed),
        .snap_o      (results)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            mu_l_q    <= '0;
            times_l_q <= '0;
            start_q   <= 1'b0;
            fx_q      <= '0;
            fmu_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            iter_q    <= '0;
            ch_q      <= '0;
        end else begin
            run_q <= run;
            if (abortable && !run) begin
                state_q <= S_ABORT;
                start_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (run_edge) begin
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        mu_l_q    <= mu;
                        times_l_q <= times;
                        ch_q      <= '0;
                        iter_q    <= '0;
                        if (times == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (!fu_done) begin
                            fx_q    <= bank_rd;
                            fmu_q   <= mu_l_q;
                            start_q <= 1'b1;
                            state_q <= S_WAIT_DONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (fu_done) begin
                            start_q <= 1'b0;
                            state_q <= S_WAIT_CLR;
                        end
                    end
                    S_WAIT_CLR: begin
                        if (!fu_done) begin
                            state_q <= S_ADVANCE;
                        end
                    end
                    S_ADVANCE: begin
                        if (last_ch) begin
                            ch_q   <= '0;
                            iter_q <= iter_next;
                            if (iter_next == times_l_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_ISSUE;
                            end
                        end else begin
                            ch_q    <= ch_q + CHW'(1);
                            state_q <= S_ISSUE;
                        end
                    end
                    S_ABORT: begin
                        if (!fu_done) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign fu_start   = start_q;
    assign fu_x       = fx_q;
    assign fu_mu      = fmu_q;
    assign busy       = busy_q;
    assign all_done   = done_q;
    assign iter_count = iter_q;
    assign cur_ch     = ch_q;

endmodule

// File: tb/tb_logistic_orbit_scheduler.sv
// Randomized self-checking bench: behavioural shared logistic unit plus a sweep-level reference model.
module tb_logistic_orbit_scheduler;
    import logistic_pkg::*;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              run = 1'b0;
    logic [MUW-1:0]    mu = '0;
    logic [CNTW-1:0]   times = '0;
    logic [W-1:0]      dzero_base = '0;
    logic              fu_start;
    logic [W-1:0]      fu_x;
    logic [MUW-1:0]    fu_mu;
    logic [W-1:0]      fu_y = '0;
    logic              fu_done;
    logic              busy;
    logic              all_done;
    logic [CNTW-1:0]   iter_count;
    logic [2:0]        cur_ch;
    logic [NCH*W-1:0]  results;

    int n_total = 0;
    int n_bad   = 0;

    logistic_orbit_scheduler #(
        .NCH  (NCH),
        .W    (W),
        .MUW  (MUW),
        .CNTW (CNTW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .run        (run),
        .mu         (mu),
        .times      (times),
        .dzero_base (dzero_base),
        .fu_start   (fu_start),
        .fu_x       (fu_x),
        .fu_mu      (fu_mu),
        .fu_y       (fu_y),
        .fu_done    (fu_done),
        .busy       (busy),
        .all_done   (all_done),
        .iter_count (iter_count),
        .cur_ch     (cur_ch),
        .results    (results)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] lmap(input logic [W-1:0] x, input logic [MUW-1:0] m);
        logic [63:0] xe, p, y;
        xe = 64'(x);
        p  = (xe * (64'(ONE) - xe)) >> FRAC;
        y  = (64'(m) * p) >> FRAC;
        return y[W-1:0];
    endfunction

    // Behavioural shared unit: level start/done, random 3..10 cycle latency per evaluation.
    logic        unit_done_q = 1'b0;
    logic        stale_hold  = 1'b0;
    int unsigned unit_cnt    = 0;
    int unsigned unit_lat    = 3;
    assign fu_done = unit_done_q | stale_hold;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            unit_done_q <= 1'b0;
            unit_cnt    <= 0;
        end else if (fu_start) begin
            if (!unit_done_q) begin
                if (unit_cnt + 1 >= unit_lat) begin
                    unit_done_q <= 1'b1;
                    fu_y        <= lmap(fu_x, fu_mu);
                end else begin
                    unit_cnt <= unit_cnt + 1;
                end
            end
        end else begin
            unit_done_q <= 1'b0;
            unit_cnt    <= 0;
            unit_lat    <= $urandom_range(10, 3);
        end
    end

    // Issue log: one entry per fu_start rising edge.
    logic           mon_prev = 1'b0;
    logic [2:0]     log_ch[$];
    logic [W-1:0]   log_x[$];
    logic [MUW-1:0] log_mu[$];

    always @(posedge CLK) begin
        if (fu_start && !mon_prev) begin
            log_ch.push_back(cur_ch);
            log_x.push_back(fu_x);
            log_mu.push_back(fu_mu);
        end
        mon_prev <= fu_start;
    end

    // Reference model: whole sweep computed as nested rounds over channels.
    logic [W-1:0]   exp_res[NCH];
    logic [W-1:0]   exp_px[$];
    logic [MUW-1:0] exp_mu;
    int             base_idx;

    task automatic model_sweep(input logic [MUW-1:0] m, input logic [CNTW-1:0] t,
                               input logic [W-1:0] b);
        logic [W-1:0] xs[NCH];
        exp_px.delete();
        exp_mu = m;
        for (int c = 0; c < NCH; c++) xs[c] = b + W'(c);
        for (int r = 0; r < int'(t); r++) begin
            for (int c = 0; c < NCH; c++) begin
                exp_px.push_back(xs[c]);
                xs[c] = lmap(xs[c], m);
            end
        end
        for (int c = 0; c < NCH; c++) exp_res[c] = xs[c];
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] res_at(input int i);
        return results[i*W +: W];
    endfunction

    task automatic start_sweep(input logic [MUW-1:0] m, input logic [CNTW-1:0] t,
                               input logic [W-1:0] b);
        @(negedge CLK);
        run = 1'b0;
        @(negedge CLK);
        mu = m;
        times = t;
        dzero_base = b;
        base_idx = log_ch.size();
        model_sweep(m, t, b);
        run = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_all_done(input int budget, input bit scramble, output int cycles);
        cycles = 1;
        while (!all_done && cycles < budget) begin
            @(negedge CLK);
            cycles++;
            if (scramble && cycles == 5) begin
                mu = 18'($urandom);
                times = 9'($urandom);
                dzero_base = 17'($urandom);
            end
        end
        chk("done_timeout", all_done, 1'b1);
    endtask

    task automatic check_sweep(input string tag);
        int n_got, n;
        n_got = log_ch.size() - base_idx;
        chk({tag, "_pulses"}, n_got, exp_px.size());
        n = (n_got < exp_px.size()) ? n_got : exp_px.size();
        for (int k = 0; k < n; k++) begin
            chk({tag, "_order"}, log_ch[base_idx + k], k % NCH);
            chk({tag, "_x"}, log_x[base_idx + k], exp_px[k]);
            chk({tag, "_mu"}, log_mu[base_idx + k], exp_mu);
        end
        for (int c = 0; c < NCH; c++) chk({tag, "_res"}, res_at(c), exp_res[c]);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_alldone"}, all_done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, fu_start, 1'b0);
        chk({tag, "_fx"}, fu_x, 0);
        chk({tag, "_fmu"}, fu_mu, 0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_alldone"}, all_done, 1'b0);
        chk({tag, "_iter"}, iter_count, 0);
        chk({tag, "_ch"}, cur_ch, 0);
        chk({tag, "_results"}, (results == '0), 1'b1);
    endtask

    initial begin
        int cyc, seen;
        logic [NCH*W-1:0] prev_res;
        logic [MUW-1:0]   rm;
        logic [CNTW-1:0]  rt;
        logic [W-1:0]     rb;

        #12;
        check_reset_outputs("rst");
        @(negedge CLK);
        RST = 1'b1;

        // Fixed point at x = 0.5 with mu = 2.0.
        start_sweep(18'h20000, 9'd4, 17'h08000);
        wait_all_done(2000, 1'b0, cyc);
        check_sweep("fixpt");
        chk("fixpt_res0", res_at(0), 17'h08000);
        chk("fixpt_n28", log_ch.size() - base_idx, 28);
        chk("fixpt_iter", iter_count, 4);

        // Zero iteration count publishes the seeds directly.
        rb = 17'($urandom_range(int'(ONE) - NCH, 0));
        start_sweep(18'h30000, 9'd0, rb);
        wait_all_done(20, 1'b0, cyc);
        chk("zero_latency", (cyc <= 3), 1'b1);
        check_sweep("zero");

        // Chaotic regime, parameters scrambled mid-sweep.
        start_sweep(18'h3E000, 9'd50, 17'h08240);
        wait_all_done(12000, 1'b1, cyc);
        check_sweep("chaos");
        chk("chaos_iter", iter_count, 50);

        for (int s = 0; s < 3; s++) begin
            rm = 18'($urandom_range(18'h3FFFF, 18'h10000));
            rt = 9'($urandom_range(6, 1));
            rb = 17'($urandom_range(int'(ONE) - NCH, 0));
            start_sweep(rm, rt, rb);
            wait_all_done(2000, 1'b1, cyc);
            check_sweep("rand");
            chk("rand_iter", iter_count, rt);
        end

        // Abort in round 3 while a start is outstanding.
        prev_res = results;
        start_sweep(18'h38000, 9'd10, 17'h04000);
        cyc = 0;
        while (!(iter_count == 2 && fu_start) && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
        end
        chk("abort_reach", (iter_count == 2 && fu_start), 1'b1);
        run = 1'b0;
        @(negedge CLK);
        chk("abort_start_drop", fu_start, 1'b0);
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        chk("abort_idle", busy, 1'b0);
        chk("abort_fudone", fu_done, 1'b0);
        chk("abort_alldone", all_done, 1'b0);
        chk("abort_results", (results == prev_res), 1'b1);
        repeat (3) @(negedge CLK);
        chk("abort_quiet", fu_start, 1'b0);

        start_sweep(18'h38000, 9'd2, 17'h04000);
        wait_all_done(2000, 1'b0, cyc);
        check_sweep("resume");

        // Stale done held across sweep start.
        @(negedge CLK);
        stale_hold = 1'b1;
        start_sweep(18'h2C000, 9'd1, 17'h0A000);
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (fu_start) seen++;
        end
        chk("stale_nostart", seen, 0);
        chk("stale_busy", busy, 1'b1);
        stale_hold = 1'b0;
        wait_all_done(500, 1'b0, cyc);
        check_sweep("stale");

        // Asynchronous reset while waiting on the unit.
        start_sweep(18'h3A000, 9'd5, 17'h06000);
        cyc = 0;
        while (!fu_start && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        chk("areset_reach", fu_start, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        check_reset_outputs("areset");
        @(negedge CLK);
        run = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
